// File: rtl/round_robin_arbiter_n_with_burst.sv
// N-way round-robin arbiter with a per-owner burst allowance.
// Grants are combinational from requests and the registered pointer/owner state.
module round_robin_arbiter_n_with_burst #(
    parameter int N         = 4,
    parameter int MAX_BURST = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         requests,
    output logic [N-1:0]         grants,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
    localparam logic [IW-1:0] LAST    = IW'(N - 1);

    logic [IW-1:0] ptr;
    logic [IW-1:0] owner;
    logic          owner_valid;
    logic [CW-1:0] cnt;

    logic [N-1:0]  others;
    logic          keep;
    logic          hit;
    logic [IW-1:0] sel;
    logic [IW-1:0] pick;
    logic          any;

    // Decide the grant: continue the current burst, else scan from ptr.
    always_comb begin
        int            j;
        logic [IW-1:0] jj;
        others        = requests;
        others[owner] = 1'b0;
        keep = owner_valid && requests[owner]
               && ((cnt < CNT_MAX) || (others == '0));
        hit  = 1'b0;
        sel  = '0;
        j    = 0;
        jj   = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            jj = IW'(j);
            if (!hit && requests[jj]) begin
                hit = 1'b1;
                sel = jj;
            end
        end
        pick        = keep ? owner : sel;
        any         = !rst && (requests != '0);
        grants      = '0;
        if (any) begin
            grants[pick] = 1'b1;
        end
        grant_valid = any;
        grant_idx   = any ? pick : '0;
    end

    // Advance burst count, owner and search pointer after each decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= '0;
            owner       <= '0;
            owner_valid <= 1'b0;
            cnt         <= '0;
        end else if (grant_valid) begin
            if (owner_valid && (grant_idx == owner)) begin
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                owner       <= grant_idx;
                owner_valid <= 1'b1;
                cnt         <= CW'(1);
            end
            ptr <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
        end else begin
            owner_valid <= 1'b0;
            cnt         <= '0;
        end
    end

endmodule
